tluh_atomic_adapter: RTL and testbench
======================================

// Module: tluh_atomic_adapter
// PURPOSE
//  Bridges a TL-UH host to a TL-UL-only device. Get/PutFullData/PutPartialData pass through.
//  ArithmeticData/LogicalData are executed as a locked Get -> ALU -> PutFullData/PutPartialData
//  sequence. Intent is acknowledged locally.
//  Sits between the crossbar device port and any TL-UL peripheral or memory lacking native atomics.
// PARAMETERS
//  MaxOutstanding  4  max in-flight pass-through requests (counter width = vbits(MaxOutstanding+1))
//  AtomicEn        1  0: atomic opcodes get an error response, no downstream access
//  IntentEn        1  0: Intent gets an error response; 1: HintAck, no downstream access
// PORTS
//  clk_i    in   1                   clock
//  rst_i    in   1                   synchronous reset, active-high
//  tl_h_i   in   $bits(tluh_h2d_t)   host request (A) + host d_ready
//  tl_h_o   out  $bits(tluh_d2h_t)   response to host (D) + a_ready
//  tl_d_o   out  $bits(tluh_h2d_t)   TL-UL request to device; opcodes limited to 0/1/4
//  tl_d_i   in   $bits(tluh_d2h_t)   device response
// BEHAVIOUR
//  Reset (rst_i=1 at a clk_i edge): state=IDLE, out_cnt=0, all capture regs 0.
//  While rst_i=1: tl_h_o.a_ready=0, tl_h_o.d_valid=0, tl_d_o.a_valid=0, tl_d_o.d_ready=0.
//  Reset mid-sequence abandons it; no D message is produced for the abandoned request.
//  FSM: IDLE, DRAIN, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP.
//  IDLE, pass-through opcode (0/1/4):
//   - A and D channels forwarded combinationally, 0 added latency.
//   - out_cnt +1 on downstream A fire, -1 on D fire, both in one cycle: no change.
//   - out_cnt==MaxOutstanding: tl_h_o.a_ready=0.
//  IDLE, Intent or atomic, or illegal request:
//   - Captured on A fire (a_ready=1 only when not forwarding): opcode, param, size, source,
//     address, mask, data.
//   - Next state: DRAIN if out_cnt!=0, else RD_REQ (atomic) or RSP (Intent/error).
//  DRAIN: a_ready=0; pass-through D still forwarded; leave when out_cnt==0.
//  RD_REQ: Get, same addr/size/source, mask=captured mask; hold a_valid until a_ready.
//  RD_WAIT: d_ready=1; on d_valid capture old=d_data, rd_err=d_error.
//   - rd_err=1 -> RSP; else -> WR_REQ.
//  WR_REQ: data = ALU(old, captured data).
//   - opcode PutFullData if mask==all-ones, else PutPartialData.
//  WR_WAIT: capture wr_err; -> RSP.
//  RSP: D to host, d_valid held until d_ready; -> IDLE.
//   - atomic: AccessAckData, d_data=old, d_error=rd_err|wr_err.
//   - Intent: HintAck, d_data=0, d_error=0.
//   - d_size/d_source echo the request; d_sink=0; d_param=0.
//  Downstream D with no pending request is ignored (d_ready=1, dropped).
//  Illegal -> RSP with d_error=1, no downstream access, d_data=0:
//   - a_size>2
//   - arith a_param>4, logical a_param>3, intent a_param>1
//   - address misaligned to a_size
//   - disabled opcode (AtomicEn/IntentEn=0)
//   - D opcode: AccessAckData for atomic/disabled atomic; HintAck for Intent/disabled Intent.
//  ALU lane rules:
//   - Operand lane = 2**a_size bytes at address[1:0]; shift down, operate, shift back.
//   - Lanes outside the operand keep old value; byte enables = captured mask.
//   - MIN/MAX signed (sign-extend from lane width); MINU/MAXU unsigned.
//   - ADD wraps modulo 2**(8*2**a_size); no carry out of lane.
//   - XOR/OR/AND bitwise; SWAP writes new data.
//  Throughput: one atomic in flight; host A stalled from capture until RSP completes.
// TESTING
//  1 Pass-through: 4 Gets back-to-back, device replies in order.
//    -> 0-cycle forwarding; 5th Get stalls when device withholds D (MaxOutstanding=4).
//  2 ADD sz=2 addr 0x100:
//    mem=0xFFFF_FFFF, data=2 -> AccessAckData d_data=0xFFFF_FFFF; mem becomes 0x0000_0001.
//  3 MIN sz=0 addr 0x103 mask 4'b1000:
//    mem=0x7F00_0000, data=0x8000_0000 -> mem 0x8000_0000; d_data=0x7F00_0000.
//  4 Atomic issued with 2 pass-through requests outstanding:
//    -> DRAIN until both D return, then Get; no reordering.
//  5 Device returns d_error=1 on the Get -> no Put issued; host gets d_error=1.
//    Logical a_param=5 -> immediate d_error=1, no downstream A.
//  6 Intent PrefetchRead -> HintAck 1 cycle after capture, no downstream A.
//    rst_i asserted during WR_WAIT -> all valids low next cycle, state IDLE.

Source files
------------

// File: rtl/tluh_atomic_adapter.sv
// TL-UH to TL-UL bridge: forwards Get/Put traffic untouched and executes
// ArithmeticData/LogicalData as a locked Get -> ALU -> Put sequence; Intent is acknowledged locally.
package tluh_atomic_pkg;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGIC       = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;
    localparam logic [2:0] OP_INTENT      = 3'd5;

    localparam logic [2:0] D_ACK          = 3'd0;
    localparam logic [2:0] D_ACK_DATA     = 3'd1;
    localparam logic [2:0] D_HINT_ACK     = 3'd2;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tluh_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [7:0]  d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tluh_d2h_t;
endpackage

module tluh_atomic_adapter
    import tluh_atomic_pkg::*;
#(
    parameter int MaxOutstanding = 4,
    parameter bit AtomicEn       = 1'b1,
    parameter bit IntentEn       = 1'b1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  tluh_h2d_t tl_h_i,
    output tluh_d2h_t tl_h_o,
    output tluh_h2d_t tl_d_o,
    input  tluh_d2h_t tl_d_i
);

    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRAIN   = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        WR_REQ  = 3'd4,
        WR_WAIT = 3'd5,
        RSP     = 3'd6
    } state_e;

    state_e          state_r;
    logic [CntW-1:0] cnt_r;
    logic [2:0]      op_r, param_r, rsp_op_r;
    logic [1:0]      size_r;
    logic [7:0]      source_r;
    logic [31:0]     addr_r, data_r, old_r;
    logic [3:0]      mask_r;
    logic            atomic_r, req_err_r, rd_err_r, wr_err_r;

    logic            is_pass_s, is_atomic_s, is_intent_s, bad_op_s, misalign_s, illegal_s;
    logic            fwd_a_s, fwd_d_s, inc_s, dec_s, cap_s;
    logic [31:0]     wr_data_s;

    // Operate on the 2**size byte lane at byte offset off; bytes outside the lane keep old_v.
    function automatic logic [31:0] alu_f(input logic [31:0] old_v, input logic [31:0] opnd,
                                          input logic [2:0] op, input logic [2:0] prm,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [4:0]  sh;
        logic [31:0] lane_m, a_l, b_l, a_x, b_x, r_l;
        sh     = {off, 3'b000};
        lane_m = (sz == 2'd0) ? 32'h0000_00FF : ((sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
        a_l    = (old_v >> sh) & lane_m;
        b_l    = (opnd >> sh) & lane_m;
        case (sz)
            2'd0:    begin a_x = {{24{a_l[7]}}, a_l[7:0]};   b_x = {{24{b_l[7]}}, b_l[7:0]};   end
            2'd1:    begin a_x = {{16{a_l[15]}}, a_l[15:0]}; b_x = {{16{b_l[15]}}, b_l[15:0]}; end
            default: begin a_x = a_l;                        b_x = b_l;                        end
        endcase
        r_l = a_l;
        if (op == OP_ARITH) begin
            case (prm)
                3'd0:    r_l = ($signed(a_x) < $signed(b_x)) ? a_l : b_l;
                3'd1:    r_l = ($signed(a_x) > $signed(b_x)) ? a_l : b_l;
                3'd2:    r_l = (a_l < b_l) ? a_l : b_l;
                3'd3:    r_l = (a_l > b_l) ? a_l : b_l;
                3'd4:    r_l = a_l + b_l;
                default: r_l = a_l;
            endcase
        end else begin
            case (prm)
                3'd0:    r_l = a_l ^ b_l;
                3'd1:    r_l = a_l | b_l;
                3'd2:    r_l = a_l & b_l;
                3'd3:    r_l = b_l;
                default: r_l = a_l;
            endcase
        end
        r_l = r_l & lane_m;
        return (old_v & ~(lane_m << sh)) | (r_l << sh);
    endfunction

    assign wr_data_s = alu_f(old_r, data_r, op_r, param_r, size_r, addr_r[1:0]);

    // Classify the incoming host request and flag anything that must be answered with an error.
    always_comb begin
        is_pass_s   = 1'b0;
        is_atomic_s = 1'b0;
        is_intent_s = 1'b0;
        bad_op_s    = 1'b0;
        case (tl_h_i.a_opcode)
            OP_PUT_FULL, OP_PUT_PARTIAL, OP_GET: is_pass_s = 1'b1;
            OP_ARITH: begin
                is_atomic_s = 1'b1;
                bad_op_s    = !AtomicEn || (tl_h_i.a_param > 3'd4);
            end
            OP_LOGIC: begin
                is_atomic_s = 1'b1;
                bad_op_s    = !AtomicEn || (tl_h_i.a_param > 3'd3);
            end
            OP_INTENT: begin
                is_intent_s = 1'b1;
                bad_op_s    = !IntentEn || (tl_h_i.a_param > 3'd1);
            end
            default: bad_op_s = 1'b1;
        endcase
        case (tl_h_i.a_size)
            2'd1:    misalign_s = tl_h_i.a_address[0];
            2'd2:    misalign_s = |tl_h_i.a_address[1:0];
            default: misalign_s = 1'b0;
        endcase
        illegal_s = bad_op_s || misalign_s || (tl_h_i.a_size > 2'd2);
    end

    // Drive both channels: combinational pass-through in IDLE/DRAIN, adapter-owned traffic elsewhere.
    always_comb begin
        tl_h_o  = '0;
        tl_d_o  = '0;
        fwd_a_s = 1'b0;
        fwd_d_s = 1'b0;
        if (rst_i) begin
            tl_h_o = '0;
            tl_d_o = '0;
        end else begin
            case (state_r)
                IDLE, DRAIN: begin
                    fwd_d_s = (cnt_r != '0);
                    if (fwd_d_s) begin
                        tl_h_o         = tl_d_i;
                        tl_d_o.d_ready = tl_h_i.d_ready;
                    end else begin
                        tl_d_o.d_ready = 1'b1;
                    end
                    if (state_r != IDLE) begin
                        tl_h_o.a_ready = 1'b0;
                    end else if (is_pass_s) begin
                        fwd_a_s        = tl_h_i.a_valid && (cnt_r != MaxCnt);
                        tl_h_o.a_ready = tl_d_i.a_ready && (cnt_r != MaxCnt);
                    end else begin
                        tl_h_o.a_ready = 1'b1;
                    end
                    tl_d_o.a_valid   = fwd_a_s;
                    tl_d_o.a_opcode  = tl_h_i.a_opcode;
                    tl_d_o.a_param   = tl_h_i.a_param;
                    tl_d_o.a_size    = tl_h_i.a_size;
                    tl_d_o.a_source  = tl_h_i.a_source;
                    tl_d_o.a_address = tl_h_i.a_address;
                    tl_d_o.a_mask    = tl_h_i.a_mask;
                    tl_d_o.a_data    = tl_h_i.a_data;
                end
                RD_REQ, WR_REQ: begin
                    tl_d_o.a_valid   = 1'b1;
                    tl_d_o.a_size    = size_r;
                    tl_d_o.a_source  = source_r;
                    tl_d_o.a_address = addr_r;
                    tl_d_o.a_mask    = mask_r;
                    tl_d_o.d_ready   = 1'b1;
                    if (state_r == RD_REQ) begin
                        tl_d_o.a_opcode = OP_GET;
                    end else begin
                        tl_d_o.a_opcode = (mask_r == 4'hF) ? OP_PUT_FULL : OP_PUT_PARTIAL;
                        tl_d_o.a_data   = wr_data_s;
                    end
                end
                RD_WAIT, WR_WAIT: tl_d_o.d_ready = 1'b1;
                RSP: begin
                    tl_d_o.d_ready  = 1'b1;
                    tl_h_o.d_valid  = 1'b1;
                    tl_h_o.d_opcode = rsp_op_r;
                    tl_h_o.d_size   = size_r;
                    tl_h_o.d_source = source_r;
                    tl_h_o.d_data   = atomic_r ? old_r : 32'h0000_0000;
                    tl_h_o.d_error  = req_err_r | rd_err_r | wr_err_r;
                end
                default: tl_d_o.d_ready = 1'b1;
            endcase
        end
    end

    assign inc_s = fwd_a_s && tl_d_i.a_ready;
    assign dec_s = fwd_d_s && tl_d_i.d_valid && tl_h_i.d_ready;
    assign cap_s = (state_r == IDLE) && tl_h_i.a_valid && !is_pass_s;

    // Sequencer state, outstanding counter and request/response capture registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            op_r      <= 3'd0;
            param_r   <= 3'd0;
            rsp_op_r  <= 3'd0;
            size_r    <= 2'd0;
            source_r  <= 8'd0;
            addr_r    <= 32'd0;
            data_r    <= 32'd0;
            old_r     <= 32'd0;
            mask_r    <= 4'd0;
            atomic_r  <= 1'b0;
            req_err_r <= 1'b0;
            rd_err_r  <= 1'b0;
            wr_err_r  <= 1'b0;
        end else begin
            if (inc_s && !dec_s) begin
                cnt_r <= cnt_r + CntW'(1);
            end else if (dec_s && !inc_s) begin
                cnt_r <= cnt_r - CntW'(1);
            end
            case (state_r)
                IDLE: begin
                    if (cap_s) begin
                        op_r      <= tl_h_i.a_opcode;
                        param_r   <= tl_h_i.a_param;
                        size_r    <= tl_h_i.a_size;
                        source_r  <= tl_h_i.a_source;
                        addr_r    <= tl_h_i.a_address;
                        mask_r    <= tl_h_i.a_mask;
                        data_r    <= tl_h_i.a_data;
                        old_r     <= 32'd0;
                        rd_err_r  <= 1'b0;
                        wr_err_r  <= 1'b0;
                        req_err_r <= illegal_s;
                        atomic_r  <= is_atomic_s && !illegal_s;
                        rsp_op_r  <= is_atomic_s ? D_ACK_DATA : (is_intent_s ? D_HINT_ACK : D_ACK);
                        if (cnt_r != '0) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= (is_atomic_s && !illegal_s) ? RD_REQ : RSP;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt_r == '0) state_r <= atomic_r ? RD_REQ : RSP;
                end
                RD_REQ: begin
                    if (tl_d_i.a_ready) state_r <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (tl_d_i.d_valid) begin
                        old_r    <= tl_d_i.d_data;
                        rd_err_r <= tl_d_i.d_error;
                        state_r  <= tl_d_i.d_error ? RSP : WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (tl_d_i.a_ready) state_r <= WR_WAIT;
                end
                WR_WAIT: begin
                    if (tl_d_i.d_valid) begin
                        wr_err_r <= tl_d_i.d_error;
                        state_r  <= RSP;
                    end
                end
                RSP: begin
                    if (tl_h_i.d_ready) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tluh_atomic_adapter.sv
// Directed bench for tluh_atomic_adapter: vector table of atomic/intent/illegal requests against
// a memory-backed device model, plus sequences for pass-through, drain and reset corner cases.
module tb_tluh_atomic_adapter;
    import tluh_atomic_pkg::*;

    logic      clk = 1'b0;
    logic      rst_i;
    tluh_h2d_t host;
    tluh_d2h_t tl_h_o;
    tluh_h2d_t tl_d_o;
    tluh_d2h_t dev_d;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] data;
        logic        err;
        logic [7:0]  src;
        logic [1:0]  sz;
    } rsp_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  prm;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] mem0;
        logic        inj;
        logic [2:0]  e_op;
        logic [31:0] e_data;
        logic        e_err;
        logic [31:0] e_mem;
        int          e_dn;
    } vec_t;

    logic [31:0] mem [0:255];
    rsp_t        dq[$];
    rsp_t        hq[$];
    int          dn_a_cnt = 0;
    logic        dev_hold = 1'b0, dev_hold_put = 1'b0, dev_err_get = 1'b0;
    int          n_cmp = 0, n_fail = 0;
    vec_t        vecs[18];

    always #5 clk = ~clk;

    tluh_atomic_adapter #(.MaxOutstanding(4), .AtomicEn(1'b1), .IntentEn(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .tl_h_i(host), .tl_h_o(tl_h_o), .tl_d_o(tl_d_o), .tl_d_i(dev_d)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Device model: always accepts A, answers in order from memory, D held by hold flags.
    initial begin
        tluh_h2d_t a_req;
        logic      a_fire, d_fire, rst_s;
        dev_d = '0;
        dev_d.a_ready = 1'b1;
        forever begin
            @(negedge clk);
            a_req  = tl_d_o;
            a_fire = tl_d_o.a_valid;
            d_fire = dev_d.d_valid && tl_d_o.d_ready;
            rst_s  = rst_i;
            @(posedge clk);
            #1;
            if (rst_s) dq.delete();
            if (d_fire && dq.size() > 0) void'(dq.pop_front());
            if (a_fire) begin
                dn_a_cnt++;
                if (a_req.a_opcode == OP_GET) begin
                    dq.push_back('{D_ACK_DATA, mem[a_req.a_address[9:2]], dev_err_get, a_req.a_source, a_req.a_size});
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (a_req.a_mask[b]) mem[a_req.a_address[9:2]][b*8 +: 8] = a_req.a_data[b*8 +: 8];
                    dq.push_back('{D_ACK, 32'h0, (a_req.a_opcode > OP_PUT_PARTIAL), a_req.a_source, a_req.a_size});
                end
            end
            dev_d = '0;
            dev_d.a_ready = 1'b1;
            if (dq.size() > 0 && !dev_hold && !(dev_hold_put && dq[0].op == D_ACK)) begin
                dev_d.d_valid  = 1'b1;
                dev_d.d_opcode = dq[0].op;
                dev_d.d_data   = dq[0].data;
                dev_d.d_error  = dq[0].err;
                dev_d.d_source = dq[0].src;
                dev_d.d_size   = dq[0].sz;
            end
        end
    end

    // Host D monitor: record every response the adapter hands to the host.
    initial begin
        forever begin
            @(negedge clk);
            if (tl_h_o.d_valid && host.d_ready)
                hq.push_back('{tl_h_o.d_opcode, tl_h_o.d_data, tl_h_o.d_error, tl_h_o.d_source, tl_h_o.d_size});
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_a(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                           input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                           input logic [7:0] src);
        host.a_valid = 1'b1; host.a_opcode = op; host.a_param = prm; host.a_size = sz;
        host.a_address = addr; host.a_mask = mask; host.a_data = data; host.a_source = src;
    endtask

    task automatic host_idle();
        host.a_valid = 1'b0; host.a_opcode = OP_GET; host.a_param = 3'd0;
    endtask

    // Present a request and hold it until accepted; called and returns at posedge+1.
    task automatic send_a(input logic [2:0] op, input logic [2:0] prm, input logic [1:0] sz,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          input logic [7:0] src);
        logic rdy;
        rdy = 1'b0;
        drive_a(op, prm, sz, addr, mask, data, src);
        for (int i = 0; i < 60 && !rdy; i++) begin
            @(negedge clk);
            rdy = tl_h_o.a_ready;
            @(posedge clk);
            #1;
        end
        if (!rdy) begin
            n_cmp++; n_fail++;
            $display("FAIL a_accept_timeout: got no a_ready expected a_ready within 60 cycles");
        end
    endtask

    task automatic wait_rsp(input int n, input string nm);
        int i;
        for (i = 0; i < 100 && hq.size() < n; i++) begin
            @(posedge clk);
            #1;
        end
        chk(nm, 32'(hq.size()), 32'(n));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base;
        rst_i = 1'b1;
        host = '0;
        host.d_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        //            op prm sz addr          mask  data          mem0          inj e_op e_data        err e_mem        dn
        vecs[0]  = '{3'd2, 3'd4, 2'd2, 32'h100, 4'hF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 3'd1, 32'hFFFF_FFFF, 1'b0, 32'h0000_0001, 2};
        vecs[1]  = '{3'd2, 3'd0, 2'd0, 32'h103, 4'h8, 32'h8000_0000, 32'h7F00_0000, 1'b0, 3'd1, 32'h7F00_0000, 1'b0, 32'h8000_0000, 2};
        vecs[2]  = '{3'd2, 3'd3, 2'd1, 32'h102, 4'hC, 32'h8000_0000, 32'h7FFF_1234, 1'b0, 3'd1, 32'h7FFF_1234, 1'b0, 32'h8000_1234, 2};
        vecs[3]  = '{3'd2, 3'd1, 2'd1, 32'h102, 4'hC, 32'h8000_0000, 32'h7FFF_1234, 1'b0, 3'd1, 32'h7FFF_1234, 1'b0, 32'h7FFF_1234, 2};
        vecs[4]  = '{3'd2, 3'd2, 2'd0, 32'h110, 4'h1, 32'h0000_0005, 32'hAAAA_AA07, 1'b0, 3'd1, 32'hAAAA_AA07, 1'b0, 32'hAAAA_AA05, 2};
        vecs[5]  = '{3'd2, 3'd4, 2'd1, 32'h114, 4'h3, 32'h0000_0001, 32'h1234_FFFF, 1'b0, 3'd1, 32'h1234_FFFF, 1'b0, 32'h1234_0000, 2};
        vecs[6]  = '{3'd3, 3'd0, 2'd2, 32'h104, 4'hF, 32'h0F0F_0F0F, 32'hFFFF_0000, 1'b0, 3'd1, 32'hFFFF_0000, 1'b0, 32'hF0F0_0F0F, 2};
        vecs[7]  = '{3'd3, 3'd1, 2'd2, 32'h108, 4'hF, 32'h00F0_00F0, 32'h1234_0000, 1'b0, 3'd1, 32'h1234_0000, 1'b0, 32'h12F4_00F0, 2};
        vecs[8]  = '{3'd3, 3'd2, 2'd0, 32'h10D, 4'h2, 32'h0000_F000, 32'h0000_3C55, 1'b0, 3'd1, 32'h0000_3C55, 1'b0, 32'h0000_3055, 2};
        vecs[9]  = '{3'd3, 3'd3, 2'd2, 32'h10C, 4'hF, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 3'd1, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 2};
        vecs[10] = '{3'd2, 3'd4, 2'd2, 32'h118, 4'hF, 32'h0000_0001, 32'h0000_0005, 1'b1, 3'd1, 32'h0000_0005, 1'b1, 32'h0000_0005, 1};
        vecs[11] = '{3'd3, 3'd5, 2'd2, 32'h11C, 4'hF, 32'h0000_0001, 32'h0000_00AB, 1'b0, 3'd1, 32'h0000_0000, 1'b1, 32'h0000_00AB, 0};
        vecs[12] = '{3'd2, 3'd5, 2'd2, 32'h11C, 4'hF, 32'h0000_0001, 32'h0000_00AB, 1'b0, 3'd1, 32'h0000_0000, 1'b1, 32'h0000_00AB, 0};
        vecs[13] = '{3'd2, 3'd4, 2'd3, 32'h120, 4'hF, 32'h0000_0001, 32'h0000_0010, 1'b0, 3'd1, 32'h0000_0000, 1'b1, 32'h0000_0010, 0};
        vecs[14] = '{3'd2, 3'd4, 2'd2, 32'h122, 4'hF, 32'h0000_0001, 32'h0000_0010, 1'b0, 3'd1, 32'h0000_0000, 1'b1, 32'h0000_0010, 0};
        vecs[15] = '{3'd5, 3'd0, 2'd2, 32'h124, 4'hF, 32'h0000_0000, 32'h0000_0033, 1'b0, 3'd2, 32'h0000_0000, 1'b0, 32'h0000_0033, 0};
        vecs[16] = '{3'd5, 3'd2, 2'd2, 32'h124, 4'hF, 32'h0000_0000, 32'h0000_0033, 1'b0, 3'd2, 32'h0000_0000, 1'b1, 32'h0000_0033, 0};
        vecs[17] = '{3'd2, 3'd0, 2'd1, 32'h128, 4'h3, 32'h0000_0001, 32'h5555_FFFE, 1'b0, 3'd1, 32'h5555_FFFE, 1'b0, 32'h5555_FFFE, 2};

        // Reset: a pending host request must not leak through while rst_i is high.
        drive_a(OP_GET, 3'd0, 2'd2, 32'h0, 4'hF, 32'h0, 8'h0);
        cycles(2);
        @(negedge clk);
        chk("rst_h_a_ready", {31'b0, tl_h_o.a_ready}, 32'd0);
        chk("rst_h_d_valid", {31'b0, tl_h_o.d_valid}, 32'd0);
        chk("rst_d_a_valid", {31'b0, tl_d_o.a_valid}, 32'd0);
        chk("rst_d_d_ready", {31'b0, tl_d_o.d_ready}, 32'd0);
        @(posedge clk);
        #1;
        host_idle();
        rst_i = 1'b0;
        cycles(1);
        chk("rst_no_dn_a", 32'(dn_a_cnt), 32'd0);

        // Table-driven atomic / intent / illegal requests.
        for (int i = 0; i < 18; i++) begin
            mem[vecs[i].addr[9:2]] = vecs[i].mem0;
            hq.delete();
            base = dn_a_cnt;
            dev_err_get = vecs[i].inj;
            send_a(vecs[i].op, vecs[i].prm, vecs[i].sz, vecs[i].addr, vecs[i].mask, vecs[i].data, 8'(i));
            host_idle();
            wait_rsp(1, $sformatf("v%0d_rsp_count", i));
            if (hq.size() > 0) begin
                chk($sformatf("v%0d_d_opcode", i), 32'(hq[0].op), 32'(vecs[i].e_op));
                chk($sformatf("v%0d_d_data", i), hq[0].data, vecs[i].e_data);
                chk($sformatf("v%0d_d_error", i), 32'(hq[0].err), 32'(vecs[i].e_err));
                chk($sformatf("v%0d_d_source", i), 32'(hq[0].src), 32'(i));
                chk($sformatf("v%0d_d_size", i), 32'(hq[0].sz), 32'(vecs[i].sz));
            end
            chk($sformatf("v%0d_mem", i), mem[vecs[i].addr[9:2]], vecs[i].e_mem);
            chk($sformatf("v%0d_dn_a", i), 32'(dn_a_cnt - base), 32'(vecs[i].e_dn));
            dev_err_get = 1'b0;
            cycles(2);
        end

        // Pass-through: four Gets forwarded in the same cycle, fifth stalls while D is withheld.
        for (int i = 0; i < 5; i++) mem[8'h80 + i] = 32'h1111_1111 * (i + 1);
        dev_hold = 1'b1;
        hq.delete();
        base = dn_a_cnt;
        for (int i = 0; i < 4; i++) begin
            drive_a(OP_GET, 3'd0, 2'd2, 32'h200 + 32'(4 * i), 4'hF, 32'h0, 8'h40 + 8'(i));
            @(negedge clk);
            chk("pt_fwd_valid", {31'b0, tl_d_o.a_valid}, 32'd1);
            chk("pt_fwd_addr", tl_d_o.a_address, 32'h200 + 32'(4 * i));
            chk("pt_a_ready", {31'b0, tl_h_o.a_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        drive_a(OP_GET, 3'd0, 2'd2, 32'h210, 4'hF, 32'h0, 8'h44);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pt_full_a_ready", {31'b0, tl_h_o.a_ready}, 32'd0);
            chk("pt_full_dn_valid", {31'b0, tl_d_o.a_valid}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("pt_dn_count", 32'(dn_a_cnt - base), 32'd4);
        dev_hold = 1'b0;
        send_a(OP_GET, 3'd0, 2'd2, 32'h210, 4'hF, 32'h0, 8'h44);
        host_idle();
        wait_rsp(5, "pt_rsp_count");
        for (int k = 0; k < 5 && k < hq.size(); k++) begin
            chk($sformatf("pt_rsp%0d_data", k), hq[k].data, 32'h1111_1111 * 32'(k + 1));
            chk($sformatf("pt_rsp%0d_src", k), 32'(hq[k].src), 32'h40 + 32'(k));
        end
        cycles(2);

        // Atomic behind two outstanding pass-through requests must drain before its Get.
        mem[8'hC0] = 32'h0000_0003;
        mem[8'hC1] = 32'h0000_0777;
        dev_hold = 1'b1;
        hq.delete();
        base = dn_a_cnt;
        send_a(OP_PUT_FULL, 3'd0, 2'd2, 32'h300, 4'hF, 32'h0000_000A, 8'h50);
        send_a(OP_GET, 3'd0, 2'd2, 32'h304, 4'hF, 32'h0, 8'h51);
        send_a(OP_ARITH, 3'd4, 2'd2, 32'h300, 4'hF, 32'h0000_0005, 8'h52);
        host_idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_no_get", 32'(dn_a_cnt - base), 32'd2);
            chk("drain_a_ready", {31'b0, tl_h_o.a_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        dev_hold = 1'b0;
        wait_rsp(3, "drain_rsp_count");
        if (hq.size() >= 3) begin
            chk("drain_put_op", 32'(hq[0].op), 32'(D_ACK));
            chk("drain_put_src", 32'(hq[0].src), 32'h50);
            chk("drain_get_data", hq[1].data, 32'h0000_0777);
            chk("drain_get_src", 32'(hq[1].src), 32'h51);
            chk("drain_atomic_data", hq[2].data, 32'h0000_000A);
            chk("drain_atomic_src", 32'(hq[2].src), 32'h52);
        end
        chk("drain_mem", mem[8'hC0], 32'h0000_000F);
        chk("drain_dn_count", 32'(dn_a_cnt - base), 32'd4);
        cycles(2);

        // Intent: HintAck visible the cycle after capture, nothing sent downstream.
        hq.delete();
        base = dn_a_cnt;
        drive_a(OP_INTENT, 3'd0, 2'd2, 32'h140, 4'hF, 32'h0, 8'h5A);
        @(negedge clk);
        chk("intent_a_ready", {31'b0, tl_h_o.a_ready}, 32'd1);
        @(posedge clk);
        #1;
        host_idle();
        @(negedge clk);
        chk("intent_1cyc_valid", {31'b0, tl_h_o.d_valid}, 32'd1);
        chk("intent_1cyc_op", 32'(tl_h_o.d_opcode), 32'(D_HINT_ACK));
        chk("intent_no_dn_a", 32'(dn_a_cnt - base), 32'd0);
        @(posedge clk);
        #1;
        cycles(2);

        // Reset while waiting for the Put acknowledge abandons the atomic silently.
        mem[8'h50] = 32'h0000_0011;
        dev_hold_put = 1'b1;
        hq.delete();
        base = dn_a_cnt;
        send_a(OP_LOGIC, 3'd3, 2'd2, 32'h140, 4'hF, 32'h0000_0099, 8'h60);
        host_idle();
        for (int i = 0; i < 40 && (dn_a_cnt - base) < 2; i++) cycles(1);
        chk("wrwait_put_issued", 32'(dn_a_cnt - base), 32'd2);
        cycles(2);
        rst_i = 1'b1;
        @(negedge clk);
        chk("rstmid_h_d_valid", {31'b0, tl_h_o.d_valid}, 32'd0);
        chk("rstmid_h_a_ready", {31'b0, tl_h_o.a_ready}, 32'd0);
        chk("rstmid_d_a_valid", {31'b0, tl_d_o.a_valid}, 32'd0);
        chk("rstmid_d_d_ready", {31'b0, tl_d_o.d_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        dev_hold_put = 1'b0;
        @(negedge clk);
        chk("rstmid_idle_a_ready", {31'b0, tl_h_o.a_ready}, 32'd1);
        chk("rstmid_idle_d_valid", {31'b0, tl_h_o.d_valid}, 32'd0);
        @(posedge clk);
        #1;
        cycles(6);
        chk("rstmid_no_rsp", 32'(hq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
